// File: rtl/parity_rx.sv
// Oversampling serial frame receiver (start, 8 data LSB first, parity, stop) with parity/framing check.
// Define PARITY_RX_SYNC_EN to pass rx_in through a two-flop synchronizer before edge detection.
module parity_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 err_clr,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_par_bit;
  logic             r_rx_prev;
  logic             w_rx;
  logic             w_cnt_clr;
  logic             w_shift;
  logic             w_par_smp;
  logic             w_stop_smp;
  logic             w_bit_last;

  function automatic logic f_parity_err(input logic [7:0] d, input logic p);
    return (^{d, p}) ^ (ODD_PARITY != 0);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] f_err_next(input logic [ERR_CNT_W-1:0] cnt,
                                                      input logic clr, input logic inc);
    if (clr)
      return '0;
    else if (inc && (cnt != {ERR_CNT_W{1'b1}}))
      return cnt + ERR_CNT_W'(1);
    else
      return cnt;
  endfunction

`ifdef PARITY_RX_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Flops reset high so a reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`else
  assign w_rx = rx_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rx_prev <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rx_prev <= w_rx;
    end
  end

  assign w_bit_last = (r_cnt == FULL_M1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx && r_rx_prev)
          w_state_nxt = S_START;
      end
      S_START: begin
        // A high line at the start-bit midpoint is treated as a glitch
        if (r_cnt == HALF_M1) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_last) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == 3'd7)
            w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_bit_last) begin
          w_cnt_clr   = 1'b1;
          w_par_smp   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_last) begin
          w_cnt_clr   = 1'b1;
          w_stop_smp  = 1'b1;
          w_state_nxt = w_rx ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        w_cnt_clr = 1'b1;
        if (w_rx)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (r_state != S_DATA)
        r_bit_idx <= '0;
      else if (w_shift)
        r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift)
        r_shift <= {w_rx, r_shift[7:1]};
      if (w_par_smp)
        r_par_bit <= w_rx;
    end
  end

  // Result registers load on the stop-sample edge, so they are visible the cycle after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= w_stop_smp;
      if (w_stop_smp) begin
        data_out   <= r_shift;
        parity_err <= f_parity_err(r_shift, r_par_bit);
        frame_err  <= ~w_rx;
      end
      err_count <= f_err_next(err_count, err_clr, data_valid && (parity_err || frame_err));
    end
  end

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: three instances (even parity, odd parity, 2-bit error counter).
module tb_parity_rx;

  localparam int C = 16;
`ifdef PARITY_RX_SYNC_EN
  localparam int DV_LAT = 171;
`else
  localparam int DV_LAT = 169;
`endif

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
    int         exp_ec;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rx      [3];
  logic       err_clr [3];
  logic [7:0] dout    [3];
  logic       dv      [3];
  logic       pe      [3];
  logic       fe      [3];
  logic [7:0] ec0;
  logic [7:0] ec1;
  logic [1:0] ec2;

  int         edge_cnt;
  int         dv_cnt  [3];
  int         dv_cyc  [3];
  logic [7:0] cap_d   [3];
  logic       cap_pe  [3];
  logic       cap_fe  [3];
  int         t_start;
  int         n_cmp;
  int         n_fail;
  vec_t       vecs    [13];

  parity_rx u0 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx[0]), .err_clr(err_clr[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .err_count(ec0)
  );

  parity_rx #(.ODD_PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx[1]), .err_clr(err_clr[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .err_count(ec1)
  );

  parity_rx #(.ERR_CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx[2]), .err_clr(err_clr[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .err_count(ec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Capture every data_valid pulse; the recorded cycle is the edge about to sample it
  initial for (int i = 0; i < 3; i++) dv_cnt[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i]) begin
        dv_cnt[i] <= dv_cnt[i] + 1;
        dv_cyc[i] <= edge_cnt + 1;
        cap_d[i]  <= dout[i];
        cap_pe[i] <= pe[i];
        cap_fe[i] <= fe[i];
      end
    end
  end

  function automatic int get_ec(input int s);
    case (s)
      0:       return int'(ec0);
      1:       return int'(ec1);
      default: return int'(ec2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                            input logic s, input bit clr);
    @(negedge clk);
    rx[sel] = 1'b0;
    t_start = edge_cnt + 1;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx[sel] = d[k];
      repeat (C) @(negedge clk);
    end
    rx[sel] = p;
    repeat (C) @(negedge clk);
    rx[sel] = s;
    for (int i = 0; i < C; i++) begin
      err_clr[sel] = clr && (i == DV_LAT - 10 * C);
      @(negedge clk);
    end
    err_clr[sel] = 1'b0;
    if (!s) begin
      rx[sel] = 1'b0;
      repeat (64) @(negedge clk);
    end
    rx[sel] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input vec_t v, input bit clr);
    int prev;
    prev = dv_cnt[v.sel];
    send_frame(v.sel, v.data, v.par, v.stop, clr);
    chk("dv_count", dv_cnt[v.sel] - prev, 1);
    chk("dv_latency", dv_cyc[v.sel] - t_start, DV_LAT);
    chk("data_out", int'(cap_d[v.sel]), int'(v.exp_d));
    chk("parity_err", int'(cap_pe[v.sel]), int'(v.exp_pe));
    chk("frame_err", int'(cap_fe[v.sel]), int'(v.exp_fe));
    chk("err_count", get_ec(v.sel), v.exp_ec);
  endtask

  initial begin
    int   prev;
    vec_t v;
    n_cmp  = 0;
    n_fail = 0;

    //            sel  data   par   stop  exp_d  pe    fe    ec
    vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 0};
    vecs[1]  = '{0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1};
    vecs[2]  = '{0, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1};
    vecs[3]  = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2};
    vecs[4]  = '{0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 2};
    vecs[5]  = '{1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0};
    vecs[6]  = '{1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1};
    vecs[7]  = '{2, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1};
    vecs[8]  = '{2, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 2};
    vecs[9]  = '{2, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3};
    vecs[10] = '{2, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3};
    vecs[11] = '{2, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3};
    vecs[12] = '{2, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx[i]      = 1'b1;
      err_clr[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_data_out", int'(dout[0]), 0);
    chk("rst_data_valid", int'(dv[0]), 0);
    chk("rst_parity_err", int'(pe[0]), 0);
    chk("rst_frame_err", int'(fe[0]), 0);
    chk("rst_err_count", get_ec(0), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 12; n++) check_frame(vecs[n], 1'b0);
    // Sixth saturating error with err_clr on its data_valid cycle
    check_frame(vecs[12], 1'b1);

    // Glitch: 4 low cycles never reach the start-bit midpoint sample
    prev = dv_cnt[0];
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_dv", dv_cnt[0] - prev, 0);
    v = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 2};
    check_frame(v, 1'b0);

    // Reset during data bit 4 of an aborted frame
    prev = dv_cnt[0];
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx[0] = k[0];
      repeat (C) @(negedge clk);
    end
    rx[0] = 1'b1;
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", int'(dout[0]), 0);
    chk("midrst_data_valid", int'(dv[0]), 0);
    chk("midrst_parity_err", int'(pe[0]), 0);
    chk("midrst_frame_err", int'(fe[0]), 0);
    chk("midrst_err_count", get_ec(0), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_dv", dv_cnt[0] - prev, 0);
    v = '{0, 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0, 0};
    check_frame(v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_rx.md
# parity_rx

Serial frame receiver and parity checker for the 8-bit parity-protected byte link. Each frame is one start bit (0), eight data bits LSB first, one parity bit and one stop bit (1). The block oversamples the line, recovers the byte, and checks it against the parity the transmitter generated. It reports parity and framing errors per byte and keeps a saturating error count for status registers.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be even and at least 4.
- ODD_PARITY, 0: 0 selects even parity, 1 selects odd parity.
- ERR_CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line; idles high.
- err_clr  in  1  synchronous clear of err_count.
- data_out  out  8  last received byte; holds until the next frame completes.
- data_valid  out  1  one-cycle pulse when data_out, parity_err and frame_err update.
- parity_err  out  1  parity mismatch on the last frame; valid with data_valid and held afterwards.
- frame_err  out  1  stop bit sampled 0 on the last frame; held like parity_err.
- err_count  out  ERR_CNT_W  saturating count of frames with any error.

## Operation
- Reset (async assert, sync release): state IDLE, bit counter and cycle counter 0. All outputs reset to 0: data_out 8'h00, data_valid, parity_err, frame_err, err_count.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_in sampled 0 while the previous sample was 1 → START, cycle counter cleared.
- START: after CLKS_PER_BIT/2 cycles (start-bit midpoint), sample rx_in.
  - 1 → glitch: back to IDLE, no output activity.
  - 0 → DATA, cycle counter cleared.
- DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After the 8th bit → PARITY.
- PARITY: after CLKS_PER_BIT cycles, sample the parity bit → STOP.
- STOP: after CLKS_PER_BIT cycles, sample the stop bit and load the outputs in the next cycle:
  - data_out gets the shift register.
  - parity_err = ^{data, parity_bit} ^ ODD_PARITY.
  - frame_err = ~stop_bit.
  - data_valid pulses.
- After STOP:
  - Stop bit 1 → IDLE immediately; the remaining half stop bit is not waited out.
  - Stop bit 0 → BREAK. BREAK holds until rx_in is sampled 1, then → IDLE. A line held low never produces further frames.
- err_count increments by 1 on the data_valid cycle if parity_err or frame_err is set, and saturates at all ones.
- err_clr has priority over a same-cycle increment: the result is 0.
- A frame with both errors increments err_count once.
- Reset mid-frame discards the partial frame. No data_valid is produced for it.

## Timing
- Let T be the cycle in which IDLE sees the falling edge (no synchronizer).
  - Start midpoint sample: T+CLKS_PER_BIT/2.
  - Data bit k (k=0..7) sample: T+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - Parity sample: T+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
  - Stop sample: T+CLKS_PER_BIT/2+10*CLKS_PER_BIT.
  - data_valid is high in the cycle after the stop sample: T+169 at CLKS_PER_BIT=16.
- Throughput: back-to-back frames are accepted. A start edge is recognised from the first IDLE cycle after STOP.
- err_count reflects a frame's error in the cycle after data_valid.

## Configuration
- PARITY_RX_SYNC_EN defined: rx_in passes through a two-flop synchronizer, reset to 1, before edge detection. All sample and data_valid times above shift by +2 cycles.
- PARITY_RX_SYNC_EN undefined: rx_in is used directly, and the source must be synchronous to clk.

## Test plan
- Good frame, even parity: byte 8'hA5, parity 0, stop 1, CLKS_PER_BIT=16 → data_out=8'hA5, one-cycle data_valid at T+169, parity_err=0, frame_err=0, err_count=0.
- Parity error: byte 8'hA5 sent with parity 1 → parity_err=1, frame_err=0, err_count=1. Then a good frame 8'h01 with parity 1 → parity_err=0, err_count stays 1. With ODD_PARITY=1, 8'hA5 with parity 1 → no error.
- Framing and break: byte 8'h3C, parity 0, stop 0, line then held low for 64 cycles → frame_err=1, err_count+1, no second data_valid. Release the line high and send 8'h55 → received cleanly.
- Glitch rejection: rx_in low for 4 cycles then high → no data_valid, FSM back in IDLE, a following frame 8'hFF is received correctly.
- Counter rules with ERR_CNT_W=2:
  - Five parity-error frames → err_count=3, saturated.
  - err_clr asserted in the same cycle as a sixth error's data_valid → err_count=0.
- Reset mid-frame: assert rst_n low during data bit 4, release, then send 8'h96 → no output for the aborted frame, all outputs 0 during reset, data_out=8'h96 afterwards. Repeat with PARITY_RX_SYNC_EN defined: data_valid at T+171.
